// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake plus APB bus signals for apb_master.
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              sel;
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata, ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, sel, enable, write, addr, wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata, ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, sel, enable, write, addr, wdata
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester (IDLE/SETUP/ACCESS).
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             reset,
    apb_master_if.master    bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;
    assign w_done   = (r_state == ACCESS) && bus.ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait;
    logic             r_rsp_error;

    // r_wait holds wait states already taken; the edge taking the last allowed one aborts
    assign w_timeout = (r_state == ACCESS) && !bus.ready && (r_wait == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait      <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_wait      <= w_accept ? '0 : (r_state == ACCESS && !bus.ready) ? r_wait + 1'b1 : r_wait;
            r_rsp_error <= w_timeout;
        end
    end

    assign bus.rsp_error = r_rsp_error;
`else
    assign w_timeout     = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.cmd_valid ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (w_done || w_timeout) ? IDLE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= w_done || w_timeout;
            if (w_accept) begin
                r_write <= bus.cmd_write;
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
            end
            if (w_done || w_timeout)
                r_rsp_rdata <= (w_done && !r_write) ? bus.rdata : '0;
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.sel       = (r_state != IDLE);
    assign bus.enable    = (r_state == ACCESS);
    assign bus.write     = r_write;
    assign bus.addr      = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule
